// File: rtl/pcl_3w_pkg.sv
// Shared definitions for the 3-wire serial link responder.
// Covers the state encodings, the read/write flag value, the synchroniser
// depth and a small width helper.
package pcl_3w_pkg;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_CMD   = 3'd1;
  localparam logic [2:0] ST_ADDR  = 3'd2;
  localparam logic [2:0] ST_WDATA = 3'd3;
  localparam logic [2:0] ST_RDATA = 3'd4;
  localparam logic [2:0] ST_DONE  = 3'd5;

  // Value of the first frame bit that marks a read.
  localparam logic TW_RW_READ = 1'b1;

  // Flops per asynchronous line before its value is trusted.
  localparam int SYNC_DEPTH = 2;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/pcl_3w_sync.sv
// Brings one asynchronous serial-link line into the system clock domain.
// It then produces single-cycle rise and fall indications from one extra
// history flop.
module pcl_3w_sync
  import pcl_3w_pkg::*;
(
  input  logic in_clk,
  input  logic in_rst,
  input  logic in_async,
  output logic out_sync,
  output logic out_rise,
  output logic out_fall
);

  logic [SYNC_DEPTH-1:0] chain_q;
  logic [SYNC_DEPTH-1:0] chain_d;
  logic                  prev_q;
  logic                  prev_d;

  // Next values: shift the raw line into the chain, remember the last synced value
  always_comb begin
    chain_d = {chain_q[SYNC_DEPTH-2:0], in_async};
    prev_d  = chain_q[SYNC_DEPTH-1];
  end

  // Synchroniser chain and edge-history flop
  always_ff @(posedge in_clk) begin
    if (in_rst) begin
      chain_q <= '0;
      prev_q  <= 1'b0;
    end else begin
      chain_q <= chain_d;
      prev_q  <= prev_d;
    end
  end

  assign out_sync = chain_q[SYNC_DEPTH-1];
  assign out_rise = out_sync & ~prev_q;
  assign out_fall = ~out_sync & prev_q;

endmodule

// File: rtl/pcl_3w_slave.sv
// Responder end of the 3-wire serial link, clocked by the local system clock.
// The serial clock, chip-select and data lines are oversampled. Each frame
// (R/W, address, data; MSB first) is decoded into single-cycle register-bus
// strobes. For read frames the read data is driven back onto the shared data
// line.
module pcl_3w_slave
  import pcl_3w_pkg::*;
#(
  parameter int PCL_3WS_ADDRESS_BITS = 7,
  parameter int PCL_3WS_DATA_BITS    = 8
) (
  input  logic                            in_clk,
  input  logic                            in_rst,
  input  logic                            in_tw_clock,
  input  logic                            in_tw_cs,
  inout  wire                             io_tw_data,
  output logic                            out_tw_dir,
  output logic [PCL_3WS_ADDRESS_BITS-1:0] out_reg_addr,
  output logic [PCL_3WS_DATA_BITS-1:0]    out_reg_wdata,
  output logic                            out_reg_wr,
  output logic                            out_reg_rd,
  input  logic [PCL_3WS_DATA_BITS-1:0]    in_reg_rdata,
  output logic                            out_busy,
  output logic                            out_frame_err
);

  localparam int AW      = PCL_3WS_ADDRESS_BITS;
  localparam int DW      = PCL_3WS_DATA_BITS;
  localparam int SHIFT_W = max_int(AW, DW);
  localparam int CNT_W   = $clog2(max_int(AW, DW) + 1);

  logic clk_rise_s, clk_fall_s, cs_sync_s, cs_rise_s, data_sync_s;
  logic clk_sync_unused_s, cs_fall_unused_s, data_rise_unused_s, data_fall_unused_s;
  logic abort_s;
  logic [CNT_W-1:0] cnt_inc_s;

  logic [2:0]         state_q, state_d;
  logic [SHIFT_W-1:0] shift_q, shift_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               rw_q, rw_d;
  logic [AW-1:0]      addr_q, addr_d;
  logic [DW-1:0]      wdata_q, wdata_d;
  logic               wr_q, wr_d;
  logic               rd_q, rd_d;
  logic               cap_q, cap_d;
  logic               dir_q, dir_d;
  logic               dout_q, dout_d;
  logic               err_q, err_d;
  logic               busy_q, busy_d;

  pcl_3w_sync u_sync_clk (
    .in_clk   (in_clk),
    .in_rst   (in_rst),
    .in_async (in_tw_clock),
    .out_sync (clk_sync_unused_s),
    .out_rise (clk_rise_s),
    .out_fall (clk_fall_s)
  );

  pcl_3w_sync u_sync_cs (
    .in_clk   (in_clk),
    .in_rst   (in_rst),
    .in_async (in_tw_cs),
    .out_sync (cs_sync_s),
    .out_rise (cs_rise_s),
    .out_fall (cs_fall_unused_s)
  );

  pcl_3w_sync u_sync_data (
    .in_clk   (in_clk),
    .in_rst   (in_rst),
    .in_async (io_tw_data),
    .out_sync (data_sync_s),
    .out_rise (data_rise_unused_s),
    .out_fall (data_fall_unused_s)
  );

  // Chip-select loss inside an active field aborts the frame; it beats any edge seen in the same cycle.
  assign abort_s   = ~cs_sync_s & ((state_q == ST_CMD)   | (state_q == ST_ADDR) |
                                   (state_q == ST_WDATA) | (state_q == ST_RDATA));
  assign cnt_inc_s = cnt_q + CNT_W'(1);

  // Frame decoder: next-state, shift register, counter, strobes and line drive
  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    cnt_d   = cnt_q;
    rw_d    = rw_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    dir_d   = dir_q;
    dout_d  = dout_q;
    wr_d    = 1'b0;
    rd_d    = 1'b0;
    err_d   = 1'b0;
    // Read data is valid one cycle after the read strobe, so capture follows it by one cycle.
    cap_d   = rd_q;
    if (abort_s) begin
      state_d = ST_IDLE;
      dir_d   = 1'b0;
      err_d   = 1'b1;
      cnt_d   = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          dir_d = 1'b0;
          if (cs_rise_s) begin
            state_d = ST_CMD;
            cnt_d   = '0;
            shift_d = '0;
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_CMD: begin
          if (clk_rise_s) begin
            rw_d    = data_sync_s;
            state_d = ST_ADDR;
            cnt_d   = '0;
            shift_d = '0;
          end else begin
            state_d = ST_CMD;
          end
        end
        ST_ADDR: begin
          if (clk_rise_s) begin
            shift_d = {shift_q[SHIFT_W-2:0], data_sync_s};
            cnt_d   = cnt_inc_s;
            if (cnt_inc_s == CNT_W'(AW)) begin
              addr_d = shift_d[AW-1:0];
              cnt_d  = '0;
              if (rw_q == TW_RW_READ) begin
                rd_d    = 1'b1;
                state_d = ST_RDATA;
              end else begin
                shift_d = '0;
                state_d = ST_WDATA;
              end
            end else begin
              state_d = ST_ADDR;
            end
          end else begin
            state_d = ST_ADDR;
          end
        end
        ST_WDATA: begin
          if (clk_rise_s) begin
            shift_d = {shift_q[SHIFT_W-2:0], data_sync_s};
            cnt_d   = cnt_inc_s;
            if (cnt_inc_s == CNT_W'(DW)) begin
              wdata_d = shift_d[DW-1:0];
              wr_d    = 1'b1;
              cnt_d   = '0;
              state_d = ST_DONE;
            end else begin
              state_d = ST_WDATA;
            end
          end else begin
            state_d = ST_WDATA;
          end
        end
        ST_RDATA: begin
          if (cap_q) begin
            shift_d = SHIFT_W'(in_reg_rdata);
          end else if (clk_fall_s) begin
            // The counter holds the number of bits already driven; once all are out, release the line.
            if (cnt_q == CNT_W'(DW)) begin
              dir_d   = 1'b0;
              cnt_d   = '0;
              state_d = ST_DONE;
            end else begin
              dir_d   = 1'b1;
              dout_d  = shift_q[DW-1];
              shift_d = {shift_q[SHIFT_W-2:0], 1'b0};
              cnt_d   = cnt_inc_s;
            end
          end else begin
            state_d = ST_RDATA;
          end
        end
        ST_DONE: begin
          dir_d = 1'b0;
          if (!cs_sync_s) begin
            state_d = ST_IDLE;
          end else begin
            state_d = ST_DONE;
          end
        end
        default: begin
          state_d = ST_IDLE;
          dir_d   = 1'b0;
          cnt_d   = '0;
        end
      endcase
    end
    busy_d = (state_d != ST_IDLE);
  end

  // Frame state and registered outputs
  always_ff @(posedge in_clk) begin
    if (in_rst) begin
      state_q <= ST_IDLE;
      shift_q <= '0;
      cnt_q   <= '0;
      rw_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      wr_q    <= 1'b0;
      rd_q    <= 1'b0;
      cap_q   <= 1'b0;
      dir_q   <= 1'b0;
      dout_q  <= 1'b0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
      rw_q    <= rw_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      cap_q   <= cap_d;
      dir_q   <= dir_d;
      dout_q  <= dout_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
    end
  end

  assign io_tw_data    = dir_q ? dout_q : 1'bz;
  assign out_tw_dir    = dir_q;
  assign out_reg_addr  = addr_q;
  assign out_reg_wdata = wdata_q;
  assign out_reg_wr    = wr_q;
  assign out_reg_rd    = rd_q;
  assign out_busy      = busy_q;
  assign out_frame_err = err_q;

endmodule
